// File: rtl/xc_malu_divrem_radix.sv
// Iterative restoring divider for div/divu/rem/remu that retires BPC quotient bits per cycle.
// Division by zero and signed overflow take a one-cycle fast path with the RISC-V results.
module xc_malu_divrem_radix #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [XLEN:0]   rem_q;
  logic [XLEN:0]   dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_sel_q;
  logic            neg_q_q;
  logic            neg_r_q;

  logic [XLEN:0]   rs1_ext;
  logic [XLEN:0]   rs2_ext;
  logic [XLEN:0]   rs1_mag;
  logic [XLEN:0]   rs2_mag;
  logic            div_zero;
  logic            overflow;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Magnitudes carry an extra bit so that |MIN| stays positive
  always_comb begin
    rs1_ext  = {op_signed & rs1[XLEN-1], rs1};
    rs2_ext  = {op_signed & rs2[XLEN-1], rs2};
    rs1_mag  = (op_signed && rs1[XLEN-1]) ? -rs1_ext : rs1_ext;
    rs2_mag  = (op_signed && rs2[XLEN-1]) ? -rs2_ext : rs2_ext;
    div_zero = (rs2 == '0);
    overflow = op_signed && (rs1 == MIN_VAL) && (rs2 == '1);
  end

  // Dividend bits shift out of the top of quo while quotient bits shift into the bottom
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    for (int i = 0; i < BPC; i++) begin
      step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
      step_quo = {step_quo[XLEN-2:0], 1'b0};
      if (step_rem >= dvs_q) begin
        step_rem    = step_rem - dvs_q;
        step_quo[0] = 1'b1;
      end
    end
  end

  always_comb begin
    q_fix = neg_q_q ? -quo_q : quo_q;
    r_fix = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  // Fast-path operands are preloaded as the final quo/rem with the counter already expired,
  // so they pass through the same sign-fix cycle one edge after acceptance
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      state     <= S_IDLE;
      result    <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_RUN;
            rem_sel_q <= op_rem;
            dvs_q     <= rs2_mag;
            if (div_zero) begin
              quo_q   <= '1;
              rem_q   <= {1'b0, rs1};
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              cnt_q   <= CW'(N);
            end else if (overflow) begin
              quo_q   <= rs1;
              rem_q   <= '0;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              cnt_q   <= CW'(N);
            end else begin
              quo_q   <= rs1_mag[XLEN-1:0];
              rem_q   <= '0;
              neg_q_q <= op_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
              neg_r_q <= op_signed && rs1[XLEN-1];
              cnt_q   <= '0;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == CW'(N)) begin
            state  <= S_DONE;
            result <= rem_sel_q ? r_fix : q_fix;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
